// File: rtl/parser_pkg.sv
// Shared constants and encodings for the signed decimal command parser.
package parser_pkg;

  // ASCII characters recognised by the parser
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_COMMA = 8'h2C;

  // Token FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SIGN   = 2'd1,
    ST_DIGITS = 2'd2,
    ST_SKIP   = 2'd3
  } state_t;

  // Byte classification
  typedef enum logic [1:0] {
    CC_DIGIT = 2'd0,
    CC_MINUS = 2'd1,
    CC_DELIM = 2'd2,
    CC_OTHER = 2'd3
  } char_class_t;

  // Rejection causes reported on err_code
  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW  = 2'b10;
  localparam logic [1:0] ERR_NO_DIGITS = 2'b11;

endpackage

// File: rtl/ascii_char_class.sv
// Combinational byte classifier: digit / minus / delimiter / other, plus digit value.
module ascii_char_class
  import parser_pkg::*;
(
  input  logic [7:0]  rx_data,
  output char_class_t char_class,
  output logic [3:0]  digit
);

  // Classify the byte; the digit value is only meaningful for CC_DIGIT
  always_comb begin
    char_class = CC_OTHER;
    digit      = 4'd0;
    if (rx_data >= CH_0 && rx_data <= CH_9) begin
      char_class = CC_DIGIT;
      digit      = rx_data[3:0];
    end else if (rx_data == CH_MINUS) begin
      char_class = CC_MINUS;
    end else if (rx_data == CH_SPACE || rx_data == CH_CR ||
                 rx_data == CH_LF    || rx_data == CH_COMMA) begin
      char_class = CC_DELIM;
    end
  end

endmodule

// File: rtl/signed_cmd_parser.sv
// Turns a UART byte stream into signed decimal integers with error reporting.
module signed_cmd_parser
  import parser_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             abort,
  output logic [WIDTH-1:0] number_out,
  output logic             number_valid,
  output logic             err_valid,
  output logic [1:0]       err_code,
  output logic             busy
);

  // Magnitude is WIDTH+1 bits; candidate math gets headroom for acc*10+9
  localparam int AW = WIDTH + 1;
  localparam int CW = WIDTH + 5;
  localparam logic [CW-1:0] LIM_POS = (CW'(1) << (WIDTH - 1)) - CW'(1);
  localparam logic [CW-1:0] LIM_NEG = CW'(1) << (WIDTH - 1);

  state_t           state_reg, state_next;
  logic [AW-1:0]    acc_reg, acc_next;
  logic             neg_reg, neg_next;
  logic             ovf_reg, ovf_next;
  logic [WIDTH-1:0] number_out_reg, number_out_next;
  logic             number_valid_reg, number_valid_next;
  logic             err_valid_reg, err_valid_next;
  logic [1:0]       err_code_reg, err_code_next;

  char_class_t      cclass;
  logic [3:0]       digit;
  logic [CW-1:0]    base, cand;
  logic             neg_eff, fits;
  logic [AW-1:0]    acc_neg;

  ascii_char_class u_class (
    .rx_data    (rx_data),
    .char_class (cclass),
    .digit      (digit)
  );

  assign acc_neg = AW'(0) - acc_reg;

  // Candidate magnitude after appending this digit; a new token starts from zero
  always_comb begin
    base    = (state_reg == ST_DIGITS) ? CW'(acc_reg) : '0;
    cand    = (base << 3) + (base << 1) + CW'(digit);
    neg_eff = (state_reg == ST_IDLE) ? 1'b0 : neg_reg;
    fits    = (cand <= (neg_eff ? LIM_NEG : LIM_POS));
  end

  // Next-state and next-output logic; abort wins over a same-cycle byte
  always_comb begin
    state_next        = state_reg;
    acc_next          = acc_reg;
    neg_next          = neg_reg;
    ovf_next          = ovf_reg;
    number_out_next   = number_out_reg;
    number_valid_next = 1'b0;
    err_valid_next    = 1'b0;
    err_code_next     = err_code_reg;
    if (abort) begin
      state_next = ST_IDLE;
      acc_next   = '0;
      neg_next   = 1'b0;
      ovf_next   = 1'b0;
    end else if (rx_valid) begin
      unique case (state_reg)
        ST_IDLE: begin
          unique case (cclass)
            CC_DIGIT: begin
              neg_next   = 1'b0;
              ovf_next   = !fits;
              acc_next   = fits ? cand[AW-1:0] : '0;
              state_next = ST_DIGITS;
            end
            CC_MINUS: begin
              neg_next   = 1'b1;
              acc_next   = '0;
              ovf_next   = 1'b0;
              state_next = ST_SIGN;
            end
            CC_DELIM: ;
            CC_OTHER: begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_ILLEGAL;
              state_next     = ST_SKIP;
            end
          endcase
        end
        ST_SIGN: begin
          unique case (cclass)
            CC_DIGIT: begin
              ovf_next   = !fits;
              acc_next   = fits ? cand[AW-1:0] : '0;
              state_next = ST_DIGITS;
            end
            CC_DELIM: begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_NO_DIGITS;
              state_next     = ST_IDLE;
            end
            default: begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_ILLEGAL;
              state_next     = ST_SKIP;
            end
          endcase
        end
        ST_DIGITS: begin
          unique case (cclass)
            CC_DIGIT: begin
              // Once overflowed the magnitude stays frozen, even if a later
              // smaller digit would happen to fit again.
              if (ovf_reg || !fits) ovf_next = 1'b1;
              else                  acc_next = cand[AW-1:0];
            end
            CC_DELIM: begin
              state_next = ST_IDLE;
              if (ovf_reg) begin
                err_valid_next = 1'b1;
                err_code_next  = ERR_OVERFLOW;
              end else begin
                number_valid_next = 1'b1;
                number_out_next   = neg_reg ? acc_neg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
              end
            end
            default: begin
              err_valid_next = 1'b1;
              err_code_next  = ERR_ILLEGAL;
              state_next     = ST_SKIP;
            end
          endcase
        end
        ST_SKIP: begin
          if (cclass == CC_DELIM) state_next = ST_IDLE;
        end
      endcase
    end
  end

  // State, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg        <= ST_IDLE;
      acc_reg          <= '0;
      neg_reg          <= 1'b0;
      ovf_reg          <= 1'b0;
      number_out_reg   <= '0;
      number_valid_reg <= 1'b0;
      err_valid_reg    <= 1'b0;
      err_code_reg     <= ERR_NONE;
    end else begin
      state_reg        <= state_next;
      acc_reg          <= acc_next;
      neg_reg          <= neg_next;
      ovf_reg          <= ovf_next;
      number_out_reg   <= number_out_next;
      number_valid_reg <= number_valid_next;
      err_valid_reg    <= err_valid_next;
      err_code_reg     <= err_code_next;
    end
  end

  assign number_out   = number_out_reg;
  assign number_valid = number_valid_reg;
  assign err_valid    = err_valid_reg;
  assign err_code     = err_code_reg;
  assign busy         = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_signed_cmd_parser.sv
// Scoreboard bench for signed_cmd_parser: token-level reference model, random byte streams.
module tb_signed_cmd_parser;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [7:0]   rx_data = 8'h00;
  logic         rx_valid = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] number_out;
  logic         number_valid;
  logic         err_valid;
  logic [1:0]   err_code;
  logic         busy;

  signed_cmd_parser #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .abort        (abort),
    .number_out   (number_out),
    .number_valid (number_valid),
    .err_valid    (err_valid),
    .err_code     (err_code),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [W-1:0] num;
    logic [1:0] code;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [W-1:0] mon_last_num = '0;

  // Reference model state: text of the current token and whether it is already rejected
  byte m_tok[$];
  bit  m_bad = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_num(input longint v);
    exp_t e;
    e.is_err = 1'b0;
    e.num    = W'(v);
    e.code   = 2'b00;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1;
    e.num    = '0;
    e.code   = c;
    exp_q.push_back(e);
  endtask

  // Evaluate a finished, syntactically valid token as a whole
  task automatic model_finish();
    bit     neg;
    longint mag;
    longint lim;
    neg = (m_tok[0] == 8'h2D);
    if (neg && m_tok.size() == 1) begin
      push_err(2'b11);
      return;
    end
    mag = 0;
    for (int i = (neg ? 1 : 0); i < m_tok.size(); i++)
      if (mag < 1000000) mag = mag * 10 + longint'(m_tok[i] - 8'h30);
    lim = neg ? (longint'(1) << (W - 1)) : (longint'(1) << (W - 1)) - 1;
    if (mag > lim) push_err(2'b10);
    else           push_num(neg ? -mag : mag);
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit is_delim;
    bit is_digit;
    is_delim = (b == 8'h20 || b == 8'h0D || b == 8'h0A || b == 8'h2C);
    is_digit = (b >= 8'h30 && b <= 8'h39);
    if (is_delim) begin
      if (!m_bad && m_tok.size() > 0) model_finish();
      m_bad = 1'b0;
      m_tok.delete();
    end else if (!m_bad) begin
      if (is_digit || (b == 8'h2D && m_tok.size() == 0)) begin
        m_tok.push_back(byte'(b));
      end else begin
        push_err(2'b01);
        m_bad = 1'b1;
        m_tok.delete();
      end
    end
  endtask

  // One clock of stimulus, applied on the falling edge
  task automatic drive(input logic [7:0] b, input bit v, input bit ab, input bit rs);
    @(negedge clk);
    rx_data  = b;
    rx_valid = v;
    abort    = ab;
    rst      = rs;
    if (rs || ab) begin
      m_tok.delete();
      m_bad = 1'b0;
      if (rs) mon_last_num = '0;
    end else if (v) begin
      model_byte(b);
    end
  endtask

  task automatic idle();
    drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      drive(s[i], 1'b1, 1'b0, 1'b0);
      if (gaps && $urandom_range(0, 3) == 0) idle();
    end
  endtask

  // Monitor: every output pulse consumes one expected event in order
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (number_valid === 1'b1 && err_valid === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL both_pulses: number_valid=1 err_valid=1 required never together");
      end
      if (number_valid === 1'b1 || err_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: nv=%0b ev=%0b num=0x%0h code=%0b required no pulse",
                   number_valid, err_valid, number_out, err_code);
        end else begin
          e = exp_q.pop_front();
          if (e.is_err) begin
            chk("err_pulse", 32'(err_valid), 32'd1);
            chk("err_code", 32'(err_code), 32'(e.code));
            chk("num_hold_on_err", 32'(number_out), 32'(mon_last_num));
          end else begin
            chk("num_pulse", 32'(number_valid), 32'd1);
            chk("number_out", 32'(number_out), 32'(e.num));
            mon_last_num = e.num;
          end
        end
      end
    end
  end

  task automatic send_random_token();
    string s;
    int    kind;
    int    v;
    kind = $urandom_range(0, 9);
    case (kind)
      0, 1, 2, 3: begin
        v = int'($urandom_range(0, 65535)) - 32768;
        s = $sformatf("%0d", v);
      end
      4: s = $sformatf("%s%0d", ($urandom_range(0, 1) == 1) ? "-" : "", $urandom_range(32760, 99999));
      5: begin
        case ($urandom_range(0, 6))
          0: s = "32767";
          1: s = "-32768";
          2: s = "32768";
          3: s = "-32769";
          4: s = "-0";
          5: s = "327680";
          default: s = "0";
        endcase
      end
      6: begin
        string alpha;
        alpha = "0123456789-ax.";
        s = "";
        for (int i = 0; i < int'($urandom_range(1, 4)); i++)
          s = {s, string'(alpha[$urandom_range(0, 13)])};
      end
      7: s = $sformatf("00%0d", $urandom_range(0, 999));
      8: s = "-";
      default: s = $sformatf("%0d", $urandom_range(0, 9));
    endcase
    for (int i = 0; i < s.len(); i++) begin
      if ($urandom_range(0, 80) == 0)
        drive(s[i], 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      else
        drive(s[i], 1'b1, 1'b0, 1'b0);
      if ($urandom_range(0, 4) == 0) idle();
    end
    case ($urandom_range(0, 4))
      0: send_str(",", 1'b0);
      1: send_str("\r\n", 1'b0);
      2: send_str("  ", 1'b1);
      default: send_str(" ", 1'b0);
    endcase
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_number_out", 32'(number_out), 32'd0);
    chk("rst_number_valid", 32'(number_valid), 32'd0);
    chk("rst_err_valid", 32'(err_valid), 32'd0);
    chk("rst_err_code", 32'(err_code), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    idle();

    // "2 ": one-cycle latency, busy drops together with the pulse
    drive(8'h32, 1'b1, 1'b0, 1'b0);
    drive(8'h20, 1'b1, 1'b0, 1'b0);
    chk("busy_mid_token", 32'(busy), 32'd1);
    idle();
    chk("lat_number_valid", 32'(number_valid), 32'd1);
    chk("lat_number_out", 32'(number_out), 32'h0002);
    chk("lat_busy", 32'(busy), 32'd0);
    idle();
    chk("pulse_width", 32'(number_valid), 32'd0);

    // Test-plan sequences, expectations from the model
    send_str("-30 40\r\n", 1'b0);
    send_str("32767 -32768 32768 ", 1'b0);
    send_str("99999999 ", 1'b0);
    send_str("1a3 5 ", 1'b0);
    send_str("- ", 1'b0);
    send_str("-- 7 ", 1'b0);
    send_str("   ", 1'b0);
    send_str("007 -0 3276 3276 ", 1'b0);

    // Abort in the same cycle as a byte, then a fresh token
    send_str("12", 1'b0);
    drive(8'h33, 1'b1, 1'b1, 1'b0);
    idle();
    chk("abort_busy", 32'(busy), 32'd0);
    send_str("7 ", 1'b0);
    repeat (3) idle();

    // Reset mid-token
    send_str("12", 1'b0);
    drive(8'h33, 1'b1, 1'b0, 1'b1);
    idle();
    chk("rst2_number_out", 32'(number_out), 32'd0);
    chk("rst2_busy", 32'(busy), 32'd0);
    chk("rst2_err_code", 32'(err_code), 32'd0);
    send_str("7 ", 1'b0);

    // Randomised token stream
    for (int t = 0; t < 600; t++) send_random_token();

    // Drain: every expected pulse should have been seen
    repeat (5) idle();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signed_cmd_parser.md
# signed_cmd_parser

Converts the byte stream from `uart_rx` into signed decimal integers for the top-level command FSM: matrix dimensions, matrix elements, opcode and scalar. It sits between `uart_rx` (`data`/`valid`) and the top FSM, which consumes `number_out`/`number_valid`. Negative values are entered as a leading `-`, so matrix data such as -30 arrives directly as two's complement. Malformed or out-of-range tokens raise an error pulse and are never delivered as numbers.

## Interface
- `WIDTH`, default 16: width of the two's-complement result.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-high.
- `rx_data`, in, 8: received byte, valid only while `rx_valid` is high.
- `rx_valid`, in, 1: single-cycle strobe from `uart_rx`; at most one byte per cycle.
- `abort`, in, 1: synchronous flush of any partial token; the top FSM drives it on timeout or restart.
- `number_out`, out, WIDTH: last completed value, signed; holds until the next completion.
- `number_valid`, out, 1: one-cycle pulse, `number_out` is new.
- `err_valid`, out, 1: one-cycle pulse, a token was rejected.
- `err_code`, out, 2: cause of the rejection, held until the next error. 01 = illegal character, 10 = magnitude overflow, 11 = sign with no digits.
- `busy`, out, 1: high while a token is partially received (state ≠ IDLE).

## Operation
- Character classes:
  - DIGIT: 0x30–0x39.
  - MINUS: 0x2D.
  - DELIM: 0x20, 0x0D, 0x0A, 0x2C.
  - OTHER: everything else.
- States: IDLE, SIGN, DIGITS, SKIP. Transitions are evaluated only on cycles with `rx_valid`=1.
- IDLE:
  - DIGIT: acc = d, neg = 0, go to DIGITS.
  - MINUS: neg = 1, acc = 0, go to SIGN.
  - DELIM: ignored, so repeated delimiters produce nothing.
  - OTHER: error 01, go to SKIP.
- SIGN:
  - DIGIT: acc = d, go to DIGITS.
  - DELIM: error 11, go to IDLE.
  - MINUS or OTHER: error 01, go to SKIP.
- DIGITS:
  - DIGIT: acc = acc*10 + d, computed as (acc<<3)+(acc<<1)+d.
  - DELIM: complete the token and go to IDLE.
  - MINUS or OTHER: error 01, go to SKIP.
- SKIP: discard bytes until a DELIM, then go to IDLE. No further error pulses are raised for the same token.
- Accumulator and overflow:
  - The accumulator is WIDTH+1 bits, unsigned magnitude.
  - Limit is 2^(WIDTH-1)-1 when positive and 2^(WIDTH-1) when negative.
  - If acc*10+d exceeds the limit, set a sticky `ovf` flag and freeze acc at its previous value so it cannot wrap.
- Completion at DELIM:
  - If `ovf` is set: error 10, no `number_valid`.
  - Otherwise: `number_out` = neg ? -acc : acc, truncated to WIDTH bits.
- Leading zeros are accepted ("007" → 7). "-0" → 0.
- `abort` (takes priority over `rx_valid` in the same cycle):
  - State goes to IDLE; acc, neg and `ovf` are cleared.
  - No pulses are generated; `number_out` and `err_code` are unchanged.
- `rst` mid-token behaves like `abort`, and additionally clears all outputs.

## Timing
- Reset values: `number_out`=0, `number_valid`=0, `err_valid`=0, `err_code`=00, `busy`=0, state IDLE, acc=0, neg=0, `ovf`=0.
- `number_valid` and `err_valid` are registered. They pulse exactly one cycle, in the cycle after the `rx_valid` that triggered them.
- Latency is 1 clk from the delimiter strobe to `number_valid`.
- There is no backpressure. The consumer must sample `number_out` on the pulse; it stays stable until the next completion.
- `number_valid` and `err_valid` are never high in the same cycle.
- Back-to-back `rx_valid` strobes on consecutive cycles must be handled. Full throughput is one byte per clock.

## Structure
- `parser_pkg` holds:
  - ASCII constants (`CH_0`, `CH_9`, `CH_MINUS`, `CH_SPACE`, `CH_CR`, `CH_LF`, `CH_COMMA`).
  - The state encoding (2 bits).
  - The `err_code` constants.
- Sub-module `ascii_char_class`: purely combinational. Maps `rx_data` to {DIGIT, MINUS, DELIM, OTHER} plus the 4-bit digit value.
- Everything else (FSM, accumulator, overflow check, output registers) lives in `signed_cmd_parser`.

## Test plan
- Send "2 " → `number_valid` exactly one cycle after the space strobe, `number_out`=0x0002, `busy` drops to 0 in the same cycle.
- Send "-30 40\r\n" → two pulses, 0xFFE2 then 0x0028. The LF after CR produces nothing.
- Send "32767 -32768 32768 " → 0x7FFF, then 0x8000, then `err_valid` with `err_code`=10 and no `number_valid`. Send "99999999 " → the same error with no wrap.
- Send "1a3 5 " → `err_valid`/01 once, at the 'a'. The "3" is discarded, then 0x0005 is delivered.
- Send "- " → error 11. Send "-- 7 " → error 01 once, then 0x0007. Send "   " → no pulses at all.
- Send "12", pulse `abort` in the same cycle as a further '3' strobe, then send "7 " → 0x0007. Repeat the sequence with `rst` in place of `abort` → outputs return to reset values, then 0x0007.
